// File: rtl/mem_pkg.sv
// Shared definitions for the stalling data-memory responder.
package mem_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, whole array cleared on reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stall_data_mem.sv
// Multi-cycle data-memory responder: captures one request, stalls the core,
// then completes it with a one-cycle done pulse LATENCY cycles after acceptance.
module stall_data_mem
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  state_t             state_next;
  logic [3:0]         cnt;
  op_t                op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata;
  logic               req;
  logic               illegal;
  logic               accept;
  logic               unused_addr_bits;

  assign req     = rd | wr;
  assign illegal = req && ((rd && wr) || addr[0]);
  assign accept  = (state == IDLE) && req && !illegal;

  // Upper address bits only make the address space wrap.
  assign unused_addr_bits = ^addr[ADDR_W-1:IDX_W+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cnt reaches zero on the edge that enters RESP, so BUSY spans LATENCY-1 cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == 4'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_RD;
      idx_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && illegal;
      if (accept) begin
        cnt    <= 4'(LATENCY - 1);
        op_q   <= wr ? OP_WR : OP_RD;
        idx_q  <= addr[IDX_W:1];
        data_q <= data_in;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .we   ((state == RESP) && (op_q == OP_WR)),
    .waddr(idx_q),
    .wdata(data_q),
    .raddr(idx_q),
    .rdata(rdata)
  );

  assign done     = (state == RESP);
  assign stall    = (state == BUSY);
  assign err      = err_q;
  assign data_out = ((state == RESP) && (op_q == OP_RD)) ? rdata : '0;

endmodule

// File: tb/tb_stall_data_mem.sv
// Bench for stall_data_mem: a LATENCY=3 and a LATENCY=1 instance share stimulus and
// are compared every cycle against a cycle-indexed request/memory reference model.
module tb_stall_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic [15:0] dout [2];
  logic [1:0]  done_v;
  logic [1:0]  stall_v;
  logic [1:0]  err_v;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int lat [2]  = '{3, 1};

  // Reference model: one pending request per instance, completing at a known cycle.
  bit          pend    [2];
  int          done_t  [2];
  bit          p_wr    [2];
  int          p_idx   [2];
  logic [15:0] p_data  [2];
  int          err_at  [2];
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  stall_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(dout[0]), .done(done_v[0]), .stall(stall_v[0]), .err(err_v[0])
  );

  stall_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(dout[1]), .done(done_v[1]), .stall(stall_v[1]), .err(err_v[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, t, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int d = 0; d < 2; d++) begin
      pend[d]   = 1'b0;
      err_at[d] = -1;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0;
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge.
  task automatic checkAndStep();
    for (int d = 0; d < 2; d++) begin
      bit          e_done;
      bit          e_stall;
      logic [15:0] e_dout;
      e_done  = pend[d] && (t == done_t[d]);
      e_stall = pend[d] && (t < done_t[d]);
      e_dout  = (e_done && !p_wr[d]) ? ref_mem[d][p_idx[d]] : 16'h0;
      checkOutput($sformatf("L%0d_done", lat[d]), 32'(done_v[d]), 32'(e_done));
      checkOutput($sformatf("L%0d_stall", lat[d]), 32'(stall_v[d]), 32'(e_stall));
      checkOutput($sformatf("L%0d_err", lat[d]), 32'(err_v[d]), 32'(t == err_at[d]));
      checkOutput($sformatf("L%0d_data_out", lat[d]), 32'(dout[d]), 32'(e_dout));
      if (e_done && !p_wr[d]) last_rd[d] = dout[d];
      if (e_done) begin
        if (p_wr[d]) ref_mem[d][p_idx[d]] = p_data[d];
        pend[d] = 1'b0;
      end else if (!pend[d] && (rd || wr)) begin
        if ((rd && wr) || addr[0]) begin
          err_at[d] = t + 1;
        end else begin
          pend[d]   = 1'b1;
          done_t[d] = t + lat[d];
          p_wr[d]   = wr;
          p_idx[d]  = (int'(addr) / 2) % 256;
          p_data[d] = data_in;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAndStep();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("L%0d_rst_done", lat[d]), 32'(done_v[d]), 32'h0);
      checkOutput($sformatf("L%0d_rst_stall", lat[d]), 32'(stall_v[d]), 32'h0);
      checkOutput($sformatf("L%0d_rst_err", lat[d]), 32'(err_v[d]), 32'h0);
      checkOutput($sformatf("L%0d_rst_data_out", lat[d]), 32'(dout[d]), 32'h0);
    end
    modelClear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    t++;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d);
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
    cycle();
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic readBoth(input logic [15:0] a, input logic [15:0] exp, input string tag);
    last_rd[0] = 16'hDEAD;
    last_rd[1] = 16'hDEAD;
    applyStimulus(1'b1, 1'b0, a, 16'h0);
    idle(3);
    checkOutput({tag, "_L3"}, 32'(last_rd[0]), 32'(exp));
    checkOutput({tag, "_L1"}, 32'(last_rd[1]), 32'(exp));
  endtask

  initial begin
    int          r;
    logic [15:0] a;
    logic [15:0] dat;

    resetPulse();

    applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle(3);
    readBoth(16'h0010, 16'hBEEF, "beef_read");

    applyStimulus(1'b0, 1'b1, 16'h0004, 16'h1234);
    applyStimulus(1'b1, 1'b0, 16'h0006, 16'hFFFF);
    idle(2);
    readBoth(16'h0004, 16'h1234, "busy_ignore_read4");
    readBoth(16'h0006, 16'h0000, "busy_ignore_read6");

    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h7777);
    idle(1);
    applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0000);
    idle(1);
    readBoth(16'h0020, 16'h0000, "err_no_access");

    applyStimulus(1'b0, 1'b1, 16'h0002, 16'h00AA);
    idle(3);
    readBoth(16'h0202, 16'h00AA, "wrap_read");

    applyStimulus(1'b0, 1'b1, 16'h0008, 16'h5555);
    resetPulse();
    readBoth(16'h0008, 16'h0000, "rst_discard_read");

    for (int i = 0; i < 8; i++) begin
      dat = 16'($urandom);
      applyStimulus(1'b0, 1'b1, 16'(2 * i), dat);
      idle(1);
      last_rd[1] = 16'hDEAD;
      applyStimulus(1'b1, 1'b0, 16'(2 * i), 16'h0);
      idle(1);
      checkOutput($sformatf("lat1_alt_read%0d", i), 32'(last_rd[1]), 32'(dat));
    end

    for (int k = 0; k < 600; k++) begin
      r  = $urandom_range(0, 9);
      rd = ((r >= 4) && (r <= 6)) || (r == 9);
      wr = (r == 7) || (r == 8) || (r == 9);
      a  = 16'($urandom) & 16'hFE3E;
      if ($urandom_range(0, 11) == 0) a[0] = 1'b1;
      addr    = a;
      data_in = 16'($urandom);
      cycle();
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
